matrix_scan_ctrl: RTL and testbench

Scan-timing generator for the 64x32 RGB LED panel (two half-panels, 1:16 scan). Produces the `col`/`row` pixel coordinates consumed by the data driver, and the panel-side shift clock, latch, output-enable and row address. The data driver turns `col`/`row` into R0/G0/B0/R1/G1/B1 combinationally, so this block alone sets the shift timing. It runs only while the game FSM asserts `en`, normally tied to `Gaming`.

---
 rtl/matrix_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : matrix_scan_ctrl
// Brief  : Scan-timing generator for a 64x32 two-half 1:16 RGB LED panel.
// Rev    : 1.0  initial release
// ============================================================================
module matrix_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ROWS      = 16,
  parameter int CLK_DIV   = 2,
  parameter int BLANK_CYC = 2,
  parameter int ON_CYC    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] row,
  output logic                    panel_clk,
  output logic                    lat,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] addr,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int c_cw = $clog2(COLS);
  localparam int c_rw = $clog2(ROWS);
  localparam int c_dw = $clog2(2 * CLK_DIV);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_shift   = 3'd1;
  localparam logic [2:0] c_blank   = 3'd2;
  localparam logic [2:0] c_latch   = 3'd3;
  localparam logic [2:0] c_display = 3'd4;

  localparam logic [c_dw-1:0] c_dcnt_last  = c_dw'(2 * CLK_DIV - 1);
  localparam logic [c_dw-1:0] c_dcnt_half  = c_dw'(CLK_DIV);
  localparam logic [c_cw-1:0] c_col_last   = c_cw'(COLS - 1);
  localparam logic [c_rw-1:0] c_row_last   = c_rw'(ROWS - 1);
  localparam logic [15:0]     c_blank_last = 16'(BLANK_CYC - 1);
  localparam logic [15:0]     c_on_last    = 16'(ON_CYC - 1);

  logic [2:0]      r_state, w_state_nxt;
  logic [c_dw-1:0] r_dcnt, w_dcnt_nxt;
  logic [15:0]     r_tmr, w_tmr_nxt;
  logic            w_dcnt_wrap;

  logic [c_cw-1:0] w_col_nxt;
  logic [c_rw-1:0] w_row_nxt, w_addr_nxt;
  logic            w_pclk_nxt, w_lat_nxt, w_oe_n_nxt, w_fdone_nxt, w_busy_nxt;

  assign w_dcnt_wrap = (r_dcnt == c_dcnt_last);

  // State register; outputs are registered alongside so every pin is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_idle;
      r_dcnt     <= '0;
      r_tmr      <= '0;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      panel_clk  <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_tmr      <= w_tmr_nxt;
      col        <= w_col_nxt;
      row        <= w_row_nxt;
      addr       <= w_addr_nxt;
      panel_clk  <= w_pclk_nxt;
      lat        <= w_lat_nxt;
      oe_n       <= w_oe_n_nxt;
      frame_done <= w_fdone_nxt;
      busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = '0;
    case (r_state)
      c_idle: begin
        if (en) w_state_nxt = c_shift;
      end
      c_shift: begin
        w_dcnt_nxt = w_dcnt_wrap ? '0 : r_dcnt + c_dw'(1);
        if (w_dcnt_wrap && (col == c_col_last)) w_state_nxt = c_blank;
      end
      c_blank: begin
        if (r_tmr == c_blank_last) w_state_nxt = c_latch;
      end
      c_latch: begin
        w_state_nxt = c_display;
      end
      c_display: begin
        if (r_tmr == c_on_last) w_state_nxt = en ? c_shift : c_idle;
      end
      default: w_state_nxt = c_idle;
    endcase
    w_tmr_nxt = (w_state_nxt != r_state) ? 16'd0 : r_tmr + 16'd1;
  end

  // Panel-side levels are decoded from the upcoming state so they line up with it.
  always_comb begin
    w_col_nxt   = col;
    w_row_nxt   = row;
    w_addr_nxt  = addr;
    w_fdone_nxt = 1'b0;
    case (r_state)
      c_idle: begin
        if (en) w_col_nxt = '0;
      end
      c_shift: begin
        if (w_dcnt_wrap && (col != c_col_last)) w_col_nxt = col + c_cw'(1);
      end
      c_blank: begin
        if (r_tmr == c_blank_last) w_addr_nxt = row;
      end
      c_latch: begin
        w_col_nxt   = '0;
        w_row_nxt   = (row == c_row_last) ? '0 : row + c_rw'(1);
        w_fdone_nxt = (row == c_row_last);
      end
      default: ;
    endcase
    w_pclk_nxt = (w_state_nxt == c_shift) && (w_dcnt_nxt >= c_dcnt_half);
    w_lat_nxt  = (w_state_nxt == c_latch);
    w_oe_n_nxt = (w_state_nxt != c_display);
    w_busy_nxt = (w_state_nxt != c_idle);
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// Bench for matrix_scan_ctrl: spot-vector table for the first lines, then
// frame, enable-drop, async-reset and fast-divider scenarios.
module tb_matrix_scan_ctrl;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic en2  = 1'b0;

  logic [5:0] col, col2;
  logic [3:0] row, row2, addr, addr2;
  logic       pclk, pclk2, lat, lat2, oe_n, oe_n2, fd, fd2, busy, busy2;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.COLS(64), .ROWS(16), .CLK_DIV(2), .BLANK_CYC(2), .ON_CYC(64)) dut (
    .clk(clk), .rst(rst), .en(en), .col(col), .row(row), .panel_clk(pclk),
    .lat(lat), .oe_n(oe_n), .addr(addr), .frame_done(fd), .busy(busy)
  );

  matrix_scan_ctrl #(.COLS(64), .ROWS(16), .CLK_DIV(1), .BLANK_CYC(2), .ON_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .col(col2), .row(row2), .panel_clk(pclk2),
    .lat(lat2), .oe_n(oe_n2), .addr(addr2), .frame_done(fd2), .busy(busy2)
  );

  typedef struct packed {
    logic [15:0] cyc;
    logic        en;
    logic [5:0]  col;
    logic [3:0]  row;
    logic        pclk;
    logic        lat;
    logic        oe_n;
    logic [3:0]  addr;
    logic        busy;
    logic        fd;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = -1000;
  logic mon_on = 1'b0;
  logic prev_pclk = 1'b0;
  int rises = 0, rises_line0 = -1, oe_low = 0, lat_cnt = 0, lat_cyc = -1;
  int col_err = 0, overlap = 0, fd_row_err = 0;
  int fd_q[$];
  int addr_seq[16];

  localparam logic [18:0] RST_OBS = {6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};

  function automatic logic [18:0] obs1();
    return {col, row, pclk, lat, oe_n, addr, busy, fd};
  endfunction

  function automatic logic [18:0] obs2();
    return {col2, row2, pclk2, lat2, oe_n2, addr2, busy2, fd2};
  endfunction

  function automatic vec_t mk(int c, int cl, int rw, logic pc, logic lt, logic oe, int ad, logic by);
    vec_t v;
    v.cyc  = 16'(c);
    v.en   = 1'b1;
    v.col  = 6'(cl);
    v.row  = 4'(rw);
    v.pclk = pc;
    v.lat  = lt;
    v.oe_n = oe;
    v.addr = 4'(ad);
    v.busy = by;
    v.fd   = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (lat && !oe_n) overlap++;
    if (mon_on && cyc >= 0) begin
      if (pclk && !prev_pclk) rises++;
      if (cyc <= 322) begin
        if (!oe_n) oe_low++;
        if (lat) begin
          lat_cnt++;
          lat_cyc = cyc;
        end
      end
      if (cyc < 256 && int'(col) != cyc / 4) col_err++;
      if (cyc == 322) rises_line0 = rises;
      if (fd) begin
        fd_q.push_back(cyc);
        if (row != 4'd0) fd_row_err++;
      end
      if ((cyc % 323) == 259 && (cyc / 323) < 16) addr_seq[cyc / 323] = int'(addr);
    end
    prev_pclk = pclk;
  endtask

  initial begin
    vec_t vecs[17];
    int idle_err, addr_err, err2, base, fd0, fdd;

    vecs[0]  = mk(0,   0,  0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[1]  = mk(1,   0,  0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[2]  = mk(2,   0,  0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    vecs[3]  = mk(3,   0,  0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    vecs[4]  = mk(4,   1,  0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[5]  = mk(6,   1,  0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    vecs[6]  = mk(127, 31, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    vecs[7]  = mk(255, 63, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    vecs[8]  = mk(256, 63, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[9]  = mk(257, 63, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[10] = mk(258, 63, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    vecs[11] = mk(259, 0,  1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    vecs[12] = mk(322, 0,  1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    vecs[13] = mk(323, 0,  1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[14] = mk(327, 1,  1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    vecs[15] = mk(581, 63, 1, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    vecs[16] = mk(582, 0,  2, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 16; i++) addr_seq[i] = -1;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("reset_vals", obs1(), RST_OBS);
    chk("reset_vals_dut2", obs2(), RST_OBS);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    cyc = -200;
    idle_err = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy || pclk || !oe_n || col != 6'd0) idle_err++;
    end
    chk("idle_hold_errs", idle_err, 0);

    en = 1'b1;
    cyc = -1;
    mon_on = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en;
      while (cyc < int'(vecs[i].cyc)) step();
      chk($sformatf("vec%0d_cyc%0d", i, vecs[i].cyc), obs1(),
          {vecs[i].col, vecs[i].row, vecs[i].pclk, vecs[i].lat, vecs[i].oe_n,
           vecs[i].addr, vecs[i].busy, vecs[i].fd});
    end
    chk("line0_pclk_rises", rises_line0, 64);
    chk("line0_oe_low_cycles", oe_low, 64);
    chk("line0_lat_count", lat_cnt, 1);
    chk("line0_lat_cycle", lat_cyc, 258);
    chk("line0_col_errs", col_err, 0);

    // Two full frames, stopping mid-DISPLAY of the first line of the third.
    while (cyc < 2 * 5168 + 300) step();
    fd0 = (fd_q.size() > 0) ? fd_q[0] : -1;
    fdd = (fd_q.size() > 1) ? fd_q[1] - fd_q[0] : -1;
    chk("frame_done_count", fd_q.size(), 2);
    chk("frame_done_first", fd0, 5104);
    chk("frame_done_period", fdd, 5168);
    chk("frame_done_row_wrap_errs", fd_row_err, 0);
    addr_err = 0;
    for (int i = 0; i < 16; i++) if (addr_seq[i] != i) addr_err++;
    chk("addr_sequence_errs", addr_err, 0);
    chk("pre_reset_display", {oe_n, row}, {1'b0, 4'd1});

    // Reset mid-DISPLAY: outputs must drop without a clock edge.
    mon_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_display_async_reset", obs1(), RST_OBS);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", obs1(), RST_OBS);
    rst = 1'b1;
    cyc = -1;
    step();
    chk("restart_after_reset", obs1(), {6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0});

    // Drop enable mid-SHIFT of line 3.
    while (cyc < 3 * 323 + 100) step();
    en = 1'b0;
    while (cyc < 3 * 323 + 322) step();
    chk("line3_still_display", {oe_n, row, busy}, {1'b0, 4'd4, 1'b1});
    step();
    chk("idle_after_drop", obs1(), {6'd0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0});
    repeat (20) step();
    chk("idle_stays", {busy, oe_n, pclk, row}, {1'b0, 1'b1, 1'b0, 4'd4});
    en = 1'b1;
    step();
    chk("resume_row4", obs1(), {6'd0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0});
    base = cyc;
    while (cyc < base + 258) step();
    chk("resume_latch", {lat, oe_n, row, addr}, {1'b1, 1'b1, 4'd4, 4'd4});
    step();
    chk("resume_display", {lat, oe_n, row, addr}, {1'b0, 1'b0, 4'd5, 4'd4});

    // CLK_DIV=1, ON_CYC=1 instance.
    en2 = 1'b1;
    step();
    err2 = 0;
    for (int k = 0; k < 128; k++) begin
      if (pclk2 !== 1'(k) || int'(col2) != k / 2 || !oe_n2 || !busy2) err2++;
      step();
    end
    chk("fast_shift_errs", err2, 0);
    chk("fast_blank", {pclk2, lat2, oe_n2, col2}, {1'b0, 1'b0, 1'b1, 6'd63});
    repeat (2) step();
    chk("fast_latch", {lat2, oe_n2, row2}, {1'b1, 1'b1, 4'd0});
    step();
    chk("fast_display", {lat2, oe_n2, row2}, {1'b0, 1'b0, 4'd1});
    step();
    chk("fast_next_line", obs2(), {6'd0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0});

    chk("lat_oe_overlap", overlap, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
